evm_booth_arbiter: RTL and testbench
====================================

// Module: evm_booth_arbiter
// PURPOSE
//  Shares one vote-tally datapath between NUM_BOOTHS voting booths under a session FSM.
//  Captures one ballot per booth request and serves pending ballots round-robin.
//  Presents each ballot to the tally through a valid/ready handshake.
//  Acknowledges each booth once its ballot is accepted by the tally.
// PARAMETERS
//  NUM_BOOTHS  4  number of booth requesters (>=2)
//  CAND_W      2  candidate code width; code 0 = no candidate (invalid)
//  WIDTH       7  width of accepted-ballot counter (saturating)
// PORTS
//  clk             in   1              clock, rising edge
//  rst             in   1              asynchronous, active-low reset
//  session_open    in   1              level; operator opens the polling session
//  session_close   in   1              1-cycle pulse; stop taking ballots, drain pending
//  booth_req       in   NUM_BOOTHS     per-booth ballot request (level)
//  booth_cand      in   NUM_BOOTHS*CAND_W  per-booth candidate code, valid with booth_req
//  booth_grant     out  NUM_BOOTHS     1-cycle pulse: booth's ballot accepted by tally
//  vote_dropped    out  1              1-cycle pulse: a request with code 0 was rejected
//  tally_valid     out  1              ballot on tally_* is valid
//  tally_cand      out  CAND_W         candidate code to count
//  tally_booth     out  $clog2(NUM_BOOTHS)  source booth index
//  tally_ready     in   1              tally accepts ballot this cycle
//  session_active  out  1              FSM in OPEN
//  session_closed  out  1              FSM in CLOSED (all ballots counted)
//  accepted_count  out  WIDTH          ballots accepted this session, saturates at all-ones
// BEHAVIOUR
//  Reset: FSM=IDLE; all pending slots, armed flags, RR pointer (=0) and count cleared.
//   All outputs 0. An asserted reset mid-operation discards in-flight ballots; no grant is issued for them.
//  FSM: IDLE -(session_open)-> OPEN -(session_close)-> DRAIN -(no pending & !tally_valid)-> CLOSED.
//   CLOSED -(!session_open)-> IDLE. IDLE->OPEN clears accepted_count.
//  Capture, OPEN only: booth i captures when booth_req[i]=1 & armed[i] & !pending[i].
//   On capture: pending[i]<=1, slot[i]<=code, armed[i]<=0.
//   armed[i] sets again only after a cycle with booth_req[i]=0, so a held button gives exactly one ballot.
//  Code 0 at capture: no slot written, armed[i]<=0, vote_dropped pulses the next cycle.
//   Several booths dropped in the same cycle give a single pulse.
//  Requests in IDLE/DRAIN/CLOSED are ignored: no capture, grant or drop.
//   session_close and a capture in the same cycle: the capture is taken and drained.
//  Arbitration: output register loads when (!tally_valid | tally_ready) and any pending.
//   The winner is the first pending index at or after rr_ptr, modulo NUM_BOOTHS.
//   Load: tally_cand/tally_booth<=slot/index, pending[win]<=0, rr_ptr<=win+1 (wraps to 0).
//  Handshake: tally_* stays stable while tally_valid & !tally_ready. Throughput is 1 ballot/cycle.
//  Accept (tally_valid & tally_ready): booth_grant[tally_booth] pulses the next cycle.
//   accepted_count increments by 1 and holds at 2^WIDTH-1.
//  Latency: req rising at cycle t -> pending at t+1 -> tally_valid at t+2 at best -> grant 1 cycle after accept.
//  Pending in DRAIN continues to be served. CLOSED is reached only after the last accept.
// STRUCTURE
//  evm_pkg: session state enum (IDLE, OPEN, DRAIN, CLOSED), CAND_NONE=0 constant.
//  Sub-module evm_rr_arbiter: NUM_BOOTHS-way round-robin; inputs pending mask, pointer; outputs win index, any.
//  Top module holds the FSM, slots, armed flags, output register, grant and count logic.
// TESTING
//  Open session; booth0 req code 2, tally_ready=1 -> tally_valid at t+2 with cand=2, booth=0.
//   Then booth_grant=0001 one cycle later and accepted_count=1.
//  All 4 booths req in one cycle, codes 1,2,3,1 -> served booths 0,1,2,3 on consecutive cycles.
//   rr_ptr ends at 0.
//  tally_ready=0 for 5 cycles while valid -> tally_cand/booth stable; no grant until ready=1.
//  booth1 holds req 10 cycles -> exactly one ballot. Drop req, re-press -> second ballot.
//  booth2 req code 0 -> vote_dropped pulses once; no tally_valid; count unchanged.
//  Two ballots pending, then session_close -> both counted, session_closed=1, new reqs ignored.
//   Assert rst mid-drain -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/evm_pkg.sv
// evm_pkg: session state encoding and shared constants for the booth arbiter.
package evm_pkg;
  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_DRAIN, S_CLOSED} state_e;
  localparam int CAND_NONE = 0;
endpackage

// File: rtl/evm_rr_arbiter.sv
// evm_rr_arbiter: picks the first pending booth at or after the pointer, wrapping.
module evm_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] win_o,
  output logic          any_o
);
  int j;
  assign any_o = |pending_i;
  // Scanning from the far end lets the nearest pending index overwrite the rest.
  always_comb begin
    win_o = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (pending_i[j]) win_o = IW'(j);
    end
  end
endmodule

// File: rtl/evm_booth_arbiter.sv
// evm_booth_arbiter: session FSM sharing one tally datapath among voting booths.
module evm_booth_arbiter
  import evm_pkg::*;
#(
  parameter int NUM_BOOTHS = 4,
  parameter int CAND_W     = 2,
  parameter int WIDTH      = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           session_open,
  input  logic                           session_close,
  input  logic [NUM_BOOTHS-1:0]          booth_req,
  input  logic [NUM_BOOTHS*CAND_W-1:0]   booth_cand,
  output logic [NUM_BOOTHS-1:0]          booth_grant,
  output logic                           vote_dropped,
  output logic                           tally_valid,
  output logic [CAND_W-1:0]              tally_cand,
  output logic [$clog2(NUM_BOOTHS)-1:0]  tally_booth,
  input  logic                           tally_ready,
  output logic                           session_active,
  output logic                           session_closed,
  output logic [WIDTH-1:0]               accepted_count
);
  localparam int IW = $clog2(NUM_BOOTHS);
  state_e state_q, state_d;
  logic [NUM_BOOTHS-1:0] pending_q, pending_d, armed_q, armed_d, take, drop_v, grant_q;
  logic [CAND_W-1:0] slot_q [NUM_BOOTHS];
  logic [CAND_W-1:0] cand_q;
  logic [IW-1:0] rr_q, win, booth_q;
  logic [WIDTH-1:0] cnt_q;
  logic any, load, accept, valid_q, drop_q;

  evm_rr_arbiter #(.N(NUM_BOOTHS), .IW(IW)) u_rr (
    .pending_i(pending_q),
    .ptr_i    (rr_q),
    .win_o    (win),
    .any_o    (any)
  );

  always_comb begin
    take   = '0;
    drop_v = '0;
    for (int i = 0; i < NUM_BOOTHS; i++) begin
      take[i]   = state_q == S_OPEN && booth_req[i] && armed_q[i] && !pending_q[i];
      drop_v[i] = take[i] && booth_cand[i*CAND_W +: CAND_W] == CAND_W'(CAND_NONE);
    end
  end

  assign load      = (!valid_q || tally_ready) && any;
  assign accept    = valid_q && tally_ready;
  // Re-arming only on a released button makes a held press worth one ballot.
  assign armed_d   = ~booth_req | (armed_q & ~take);
  assign pending_d = (pending_q & ~(load ? NUM_BOOTHS'(1) << win : '0)) | (take & ~drop_v);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = session_open ? S_OPEN : S_IDLE;
      S_OPEN:   state_d = session_close ? S_DRAIN : S_OPEN;
      S_DRAIN:  state_d = (!any && !valid_q) ? S_CLOSED : S_DRAIN;
      S_CLOSED: state_d = session_open ? S_CLOSED : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      armed_q   <= '0;
      rr_q      <= '0;
      valid_q   <= 1'b0;
      cand_q    <= '0;
      booth_q   <= '0;
      grant_q   <= '0;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
      for (int i = 0; i < NUM_BOOTHS; i++) slot_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      armed_q   <= armed_d;
      drop_q    <= |drop_v;
      grant_q   <= accept ? NUM_BOOTHS'(1) << booth_q : '0;
      for (int i = 0; i < NUM_BOOTHS; i++)
        if (take[i] && !drop_v[i]) slot_q[i] <= booth_cand[i*CAND_W +: CAND_W];
      if (load) begin
        valid_q <= 1'b1;
        cand_q  <= slot_q[win];
        booth_q <= win;
        rr_q    <= (win == IW'(NUM_BOOTHS - 1)) ? '0 : win + 1'b1;
      end else if (tally_ready) begin
        valid_q <= 1'b0;
      end
      if (state_q == S_IDLE && session_open) cnt_q <= '0;
      else if (accept && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign booth_grant    = grant_q;
  assign vote_dropped   = drop_q;
  assign tally_valid    = valid_q;
  assign tally_cand     = cand_q;
  assign tally_booth    = booth_q;
  assign session_active = state_q == S_OPEN;
  assign session_closed = state_q == S_CLOSED;
  assign accepted_count = cnt_q;
endmodule

// File: tb/tb_evm_booth_arbiter.sv
// tb_evm_booth_arbiter: directed session scenarios with a ballot scoreboard.
module tb_evm_booth_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       session_open = 1'b0, session_close = 1'b0, tally_ready = 1'b0;
  logic [3:0] booth_req = '0, booth_grant;
  logic [7:0] booth_cand = '0;
  logic       vote_dropped, tally_valid, session_active, session_closed;
  logic [1:0] tally_cand, tally_booth;
  logic [6:0] accepted_count;
  logic [3:0] exp_q [$];
  logic [3:0] exp_grant = '0;
  logic [3:0] exp_ballot;
  int n_chk = 0, n_fail = 0;

  evm_booth_arbiter dut (
    .clk(clk), .rst(rst), .session_open(session_open), .session_close(session_close),
    .booth_req(booth_req), .booth_cand(booth_cand), .booth_grant(booth_grant),
    .vote_dropped(vote_dropped), .tally_valid(tally_valid), .tally_cand(tally_cand),
    .tally_booth(tally_booth), .tally_ready(tally_ready), .session_active(session_active),
    .session_closed(session_closed), .accepted_count(accepted_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m, input logic [7:0] c);
    booth_req  = m;
    booth_cand = c;
  endtask

  // Grants follow accepts by one cycle; accepted ballots are matched against the queue.
  always @(negedge clk) begin
    check("grant", booth_grant, rst ? exp_grant : 4'h0);
    exp_grant = (rst && tally_valid && tally_ready) ? 4'b0001 << tally_booth : 4'h0;
    if (rst && tally_valid && tally_ready) begin
      check("ballot_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_ballot = exp_q.pop_front();
        check("ballot", {tally_booth, tally_cand}, exp_ballot);
      end
    end
  end

  initial begin
    tick();
    check("rst_valid", tally_valid, 0);
    check("rst_active", session_active, 0);
    check("rst_closed", session_closed, 0);
    check("rst_count", accepted_count, 0);
    check("rst_drop", vote_dropped, 0);
    rst = 1'b1;
    tick();
    session_open = 1'b1;
    tick();
    check("open_active", session_active, 1);
    tally_ready = 1'b1;
    exp_q.push_back({2'd0, 2'd2});
    press(4'b0001, 8'h02);
    tick();
    press(4'b0000, 8'h00);
    check("t1_pending_not_valid", tally_valid, 0);
    tick();
    check("t1_valid", tally_valid, 1);
    check("t1_cand", tally_cand, 2);
    check("t1_booth", tally_booth, 0);
    tick();
    check("t1_grant", booth_grant, 4'b0001);
    check("t1_count", accepted_count, 1);
    exp_q.push_back({2'd3, 2'd3});
    press(4'b1000, 8'hC0);
    tick();
    press(4'b0000, 8'h00);
    repeat (3) tick();
    check("t1b_count", accepted_count, 2);
    exp_q.push_back({2'd0, 2'd1});
    exp_q.push_back({2'd1, 2'd2});
    exp_q.push_back({2'd2, 2'd3});
    exp_q.push_back({2'd3, 2'd1});
    press(4'b1111, {2'd1, 2'd3, 2'd2, 2'd1});
    tick();
    press(4'b0000, 8'h00);
    for (int b = 0; b < 4; b++) begin
      tick();
      check("t2_order", tally_booth, b);
    end
    tick();
    check("t2_idle", tally_valid, 0);
    check("t2_count", accepted_count, 6);
    tally_ready = 1'b0;
    exp_q.push_back({2'd1, 2'd2});
    exp_q.push_back({2'd3, 2'd1});
    press(4'b1010, {2'd1, 2'd0, 2'd2, 2'd0});
    tick();
    press(4'b0000, 8'h00);
    tick();
    check("t3_valid", tally_valid, 1);
    for (int s = 0; s < 5; s++) begin
      tick();
      check("t3_hold_valid", tally_valid, 1);
      check("t3_hold_booth", tally_booth, 1);
      check("t3_hold_cand", tally_cand, 2);
    end
    tally_ready = 1'b1;
    tick();
    check("t3_next_booth", tally_booth, 3);
    check("t3_next_cand", tally_cand, 1);
    tick();
    check("t3_done", tally_valid, 0);
    check("t3_count", accepted_count, 8);
    exp_q.push_back({2'd1, 2'd1});
    press(4'b0010, 8'h04);
    repeat (10) tick();
    check("t4_held_count", accepted_count, 9);
    press(4'b0000, 8'h00);
    tick();
    exp_q.push_back({2'd1, 2'd1});
    press(4'b0010, 8'h04);
    tick();
    press(4'b0000, 8'h00);
    repeat (3) tick();
    check("t4_repress_count", accepted_count, 10);
    press(4'b0100, 8'h00);
    tick();
    check("t5_drop", vote_dropped, 1);
    check("t5_no_valid", tally_valid, 0);
    tick();
    check("t5_drop_once", vote_dropped, 0);
    press(4'b0000, 8'h00);
    tick();
    press(4'b0101, 8'h00);
    tick();
    check("t5_multi_drop", vote_dropped, 1);
    tick();
    check("t5_multi_once", vote_dropped, 0);
    press(4'b0000, 8'h00);
    tick();
    check("t5_count", accepted_count, 10);
    check("t5_valid", tally_valid, 0);
    tally_ready = 1'b0;
    exp_q.push_back({2'd2, 2'd2});
    exp_q.push_back({2'd0, 2'd3});
    press(4'b0101, {2'd0, 2'd2, 2'd0, 2'd3});
    session_close = 1'b1;
    tick();
    session_close = 1'b0;
    press(4'b0000, 8'h00);
    check("t6_drain", session_active, 0);
    tick();
    check("t6_first_booth", tally_booth, 2);
    press(4'b0010, 8'h04);
    repeat (2) tick();
    check("t6_not_closed", session_closed, 0);
    check("t6_held", tally_valid, 1);
    tally_ready = 1'b1;
    repeat (3) tick();
    check("t6_closed", session_closed, 1);
    check("t6_count", accepted_count, 12);
    press(4'b0000, 8'h00);
    check("t6_queue_empty", exp_q.size(), 0);
    session_open = 1'b0;
    tick();
    check("t7_idle", session_closed, 0);
    session_open = 1'b1;
    tick();
    check("t7_reopen_active", session_active, 1);
    check("t7_count_clear", accepted_count, 0);
    tally_ready = 1'b0;
    press(4'b1000, 8'h80);
    session_close = 1'b1;
    tick();
    session_close = 1'b0;
    press(4'b0000, 8'h00);
    tick();
    check("t7_inflight", tally_valid, 1);
    rst = 1'b0;
    #1;
    check("t7_rst_valid", tally_valid, 0);
    check("t7_rst_active", session_active, 0);
    check("t7_rst_closed", session_closed, 0);
    check("t7_rst_count", accepted_count, 0);
    check("t7_rst_grant", booth_grant, 0);
    session_open = 1'b0;
    tick();
    rst = 1'b1;
    tally_ready = 1'b1;
    repeat (3) tick();
    check("t7_no_revive", tally_valid, 0);
    check("t7_still_idle", session_active, 0);
    check("t7_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
